// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared mode encoding and width helpers for the multimode arbiter
package arb_pkg;

  typedef enum logic [1:0] {
    FP_PREEMPT = 2'd0,
    FP_LOCK    = 2'd1,
    RR_LOCK    = 2'd2
  } arb_mode_e;

  function automatic int calc_idw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Counter only needs to reach MAX_HOLD-1; a disabled limit keeps one bit.
  function automatic int calc_hold_w(input int max_hold);
    return (max_hold < 2) ? 1 : $clog2(max_hold);
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - combinational rotating-priority picker (first set bit from a start index)
module arb_rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_cand,
  input  logic [IDW-1:0] i_start,
  output logic [N-1:0]   o_onehot,
  output logic [IDW-1:0] o_idx,
  output logic           o_found
);

  int             j;
  logic [IDW-1:0] jj;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_found  = 1'b0;
    j        = 0;
    jj       = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(i_start) + i;
      if (j >= N) j = j - N;
      jj = IDW'(j);
      if (!o_found && i_cand[jj]) begin
        o_found      = 1'b1;
        o_onehot[jj] = 1'b1;
        o_idx        = jj;
      end
    end
  end

endmodule

// File: rtl/arb_multimode.sv
// rtl/arb_multimode.sv - registered N-way arbiter with preemptive/locked fixed priority and locked round robin
module arb_multimode
  import arb_pkg::*;
#(
  parameter int  REQ_NUM  = 4,
  parameter int  MAX_HOLD = 16,
  localparam int IDW      = calc_idw(REQ_NUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic [REQ_NUM-1:0] req,
  output logic [REQ_NUM-1:0] grant,
  output logic [IDW-1:0]     grant_id,
  output logic               grant_valid
);

  localparam int             HW        = calc_hold_w(MAX_HOLD);
  localparam bit             HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HW-1:0]  HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);

  logic [REQ_NUM-1:0] r_grant;
  logic [IDW-1:0]     r_grant_id;
  logic               r_grant_valid;
  logic [IDW-1:0]     r_rr_ptr;
  logic [HW-1:0]      r_hold_cnt;

  arb_mode_e          w_mode;
  logic               w_locking;
  logic               w_owner_req;
  logic               w_others;
  logic               w_at_limit;
  logic               w_keep;
  logic               w_excl;
  logic [REQ_NUM-1:0] w_cand;
  logic [REQ_NUM-1:0] w_fp_onehot;
  logic [IDW-1:0]     w_fp_idx;
  logic               w_fp_found;
  logic [REQ_NUM-1:0] w_rr_onehot;
  logic [IDW-1:0]     w_rr_idx;
  logic               w_rr_found;
  logic               w_use_rr;
  logic [REQ_NUM-1:0] w_pick_onehot;
  logic [IDW-1:0]     w_pick_idx;
  logic               w_pick_found;
  logic [REQ_NUM-1:0] w_next_grant;
  logic [IDW-1:0]     w_next_id;
  logic [HW-1:0]      w_next_hold;
  logic [IDW-1:0]     w_next_ptr;

  assign w_mode      = arb_mode_e'(mode);
  assign w_locking   = (w_mode != FP_PREEMPT);
  assign w_owner_req = |(req & r_grant);
  assign w_others    = |(req & ~r_grant);
  assign w_at_limit  = HOLD_EN && (r_hold_cnt == HOLD_LAST);
  assign w_keep      = w_locking && w_owner_req && !w_at_limit;
  // An expired owner steps aside only when someone else is waiting.
  assign w_excl      = w_locking && w_owner_req && w_at_limit && w_others;
  assign w_cand      = w_excl ? (req & ~r_grant) : req;
  assign w_use_rr    = (w_mode == RR_LOCK);

  arb_rr_pick #(.N(REQ_NUM), .IDW(IDW)) u_fp_pick (
    .i_cand   (w_cand),
    .i_start  ('0),
    .o_onehot (w_fp_onehot),
    .o_idx    (w_fp_idx),
    .o_found  (w_fp_found)
  );

  arb_rr_pick #(.N(REQ_NUM), .IDW(IDW)) u_rr_pick (
    .i_cand   (w_cand),
    .i_start  (r_rr_ptr),
    .o_onehot (w_rr_onehot),
    .o_idx    (w_rr_idx),
    .o_found  (w_rr_found)
  );

  assign w_pick_onehot = w_use_rr ? w_rr_onehot : w_fp_onehot;
  assign w_pick_idx    = w_use_rr ? w_rr_idx    : w_fp_idx;
  assign w_pick_found  = w_use_rr ? w_rr_found  : w_fp_found;

  always_comb begin
    w_next_grant = w_pick_onehot;
    w_next_hold  = '0;
    w_next_ptr   = r_rr_ptr;
    if (w_keep) begin
      w_next_grant = r_grant;
      w_next_hold  = (r_hold_cnt == '1) ? r_hold_cnt : r_hold_cnt + 1'b1;
    end else if (w_use_rr && w_pick_found) begin
      w_next_ptr = (w_pick_idx == IDW'(REQ_NUM - 1)) ? '0 : w_pick_idx + 1'b1;
    end
  end

  always_comb begin
    w_next_id = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (w_next_grant[i]) w_next_id = w_next_id | IDW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_rr_ptr      <= '0;
      r_hold_cnt    <= '0;
    end else begin
      r_grant       <= w_next_grant;
      r_grant_id    <= w_next_id;
      r_grant_valid <= |w_next_grant;
      r_rr_ptr      <= w_next_ptr;
      r_hold_cnt    <= w_next_hold;
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign grant_valid = r_grant_valid;

endmodule

// File: tb/tb_arb_multimode.sv
// tb/tb_arb_multimode.sv - directed and randomized checks of arb_multimode (REQ_NUM=4, MAX_HOLD=4)
module tb_arb_multimode;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;

  int n_vec;
  int n_err;

  arb_multimode #(.REQ_NUM(4), .MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .req         (req),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_g(input string tag, input logic [3:0] eg, input logic [1:0] eid);
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".id"}, 32'(grant_id), 32'(eid));
    chk({tag, ".valid"}, 32'(grant_valid), 32'(eg != 4'b0));
  endtask

  // Directed table for the round-robin rotation: req, expected grant, id, rr_ptr
  logic [3:0] rr_req [5] = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] rr_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] rr_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [1:0] rr_ptr [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    logic [3:0] prev_req;
    logic [1:0] exp_id;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    mode  = 2'd0;
    req   = 4'b0;
    tick();
    tick();
    chk_g("reset", 4'b0, 2'd0);
    chk("reset.rr_ptr", 32'(dut.r_rr_ptr), 0);
    chk("reset.hold", 32'(dut.r_hold_cnt), 0);
    rst_n = 1'b1;

    // FP_PREEMPT: lower index preempts
    mode = 2'd0; req = 4'b1000; tick();
    chk_g("fpp.first", 4'b1000, 2'd3);
    req = 4'b1010; tick();
    chk_g("fpp.preempt", 4'b0010, 2'd1);
    chk("fpp.rr_ptr", 32'(dut.r_rr_ptr), 0);
    chk("fpp.hold", 32'(dut.r_hold_cnt), 0);

    // FP_LOCK: owner 3 locked against higher priority
    mode = 2'd1; req = 4'b1000; tick();
    chk_g("fpl.own3", 4'b1000, 2'd3);
    req = 4'b1111; tick();
    chk_g("fpl.lock1", 4'b1000, 2'd3);
    tick();
    chk_g("fpl.lock2", 4'b1000, 2'd3);
    chk("fpl.hold", 32'(dut.r_hold_cnt), 2);
    req = 4'b0111; tick();
    chk_g("fpl.release", 4'b0001, 2'd0);
    req = 4'b0000; tick();
    chk_g("fpl.idle", 4'b0000, 2'd0);

    // RR_LOCK rotation with each owner dropping after one cycle
    mode = 2'd2;
    for (int i = 0; i < 5; i++) begin
      req = rr_req[i]; tick();
      chk_g($sformatf("rr.step%0d", i), rr_gnt[i], rr_id[i]);
      chk($sformatf("rr.ptr%0d", i), 32'(dut.r_rr_ptr), 32'(rr_ptr[i]));
    end
    req = 4'b0000; tick();
    chk_g("rr.idle", 4'b0000, 2'd0);
    chk("rr.idle_ptr", 32'(dut.r_rr_ptr), 1);

    // Asynchronous reset while owner 2 holds
    req = 4'b0100; tick();
    chk_g("rst.pre", 4'b0100, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    chk_g("rst.async", 4'b0000, 2'd0);
    chk("rst.ptr", 32'(dut.r_rr_ptr), 0);
    mode = 2'd1;
    tick();
    rst_n = 1'b1;
    chk_g("rst.held", 4'b0000, 2'd0);
    tick();
    chk_g("rst.regrant", 4'b0100, 2'd2);
    chk("rst.ptr_after", 32'(dut.r_rr_ptr), 0);

    // Hold limit 4 in RR_LOCK with two contenders
    mode = 2'd2; req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_g($sformatf("hold.own0_%0d", i), 4'b0001, 2'd0);
      chk($sformatf("hold.cnt0_%0d", i), 32'(dut.r_hold_cnt), 32'(i));
    end
    tick();
    chk_g("hold.expire", 4'b0010, 2'd1);
    chk("hold.cnt_new", 32'(dut.r_hold_cnt), 0);
    chk("hold.ptr", 32'(dut.r_rr_ptr), 2);

    // Lone requestor re-granted after expiry
    req = 4'b0010;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("solo.cnt%0d", i), 32'(dut.r_hold_cnt), 32'(i));
    end
    tick();
    chk_g("solo.regrant", 4'b0010, 2'd1);
    chk("solo.cnt_reset", 32'(dut.r_hold_cnt), 0);

    // Switching to FP_PREEMPT releases the lock
    mode = 2'd0; req = 4'b0011; tick();
    chk_g("sw.preempt", 4'b0001, 2'd0);

    // Random stress: structural invariants only
    for (int c = 0; c < 10000; c++) begin
      prev_req = 4'($urandom);
      req  = prev_req;
      mode = 2'($urandom_range(0, 3));
      tick();
      exp_id = 2'd0;
      for (int b = 0; b < 4; b++) if (grant[b]) exp_id = 2'(b);
      chk("rnd.onehot0", 32'($onehot0(grant)), 1);
      chk("rnd.valid", 32'(grant_valid), 32'(|grant));
      chk("rnd.id", 32'(grant_id), 32'(exp_id));
      chk("rnd.req_seen", 32'(grant & ~prev_req), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arb_multimode.md
# arb_multimode

Parametrised, registered N-way arbiter and the successor to the fixed-priority absolute arbiter. It adds three runtime modes: preemptive fixed priority, non-preemptive fixed priority, and non-preemptive round robin. It also adds grant locking, a hold-time limit that forces re-arbitration, and encoded grant outputs. It sits in front of shared resources (bus master port, memory bank, shared engine) where requestors assert a level request and keep it high for the whole transaction.

## Interface
- REQ_NUM, 4: number of requestors, 2..32.
- MAX_HOLD, 16: maximum consecutive cycles one owner may hold a locked grant. 0 disables the limit.
- IDW, max(1,$clog2(REQ_NUM)): width of grant_id (derived).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mode  in  2  0 = FP_PREEMPT, 1 = FP_LOCK, 2 = RR_LOCK, 3 = reserved (behaves as FP_LOCK). Sampled every cycle.
- req  in  REQ_NUM  level requests; bit 0 has the highest fixed priority.
- grant  out  REQ_NUM  registered grant, one-hot or all-zero.
- grant_id  out  IDW  index of the granted requestor. 0 when grant_valid=0.
- grant_valid  out  1  equals |grant.

## Operation
- State registers:
  - grant (one-hot owner)
  - rr_ptr (IDW bits): requestor with highest RR priority
  - hold_cnt: saturating count of cycles the current owner has held
- Reset values: grant=0, grant_id=0, grant_valid=0, rr_ptr=0, hold_cnt=0.
- Keep condition, evaluated each cycle: there is an owner o, mode≠0, req[o]=1, and (MAX_HOLD=0 or hold_cnt < MAX_HOLD-1). If it holds, grant is unchanged and hold_cnt increments.
- Expiry: an owner still requesting with hold_cnt = MAX_HOLD-1 is excluded from the candidate set, but only if some other req bit is set. If no other bit is set, the owner is re-granted and hold_cnt restarts at 0.
- Arbitration (keep condition false), over the candidate set C = req minus any excluded owner:
  - FP_PREEMPT: grant goes to the lowest index in C, recomputed every cycle with no locking. This is identical to the legacy absolute arbiter.
  - FP_LOCK / reserved: grant goes to the lowest index in C.
  - RR_LOCK: grant goes to the first set bit in C, searching rr_ptr, rr_ptr+1, … modulo REQ_NUM.
  - C empty: grant=0.
- rr_ptr update: on every new grant to index i in RR_LOCK, rr_ptr ← (i+1) mod REQ_NUM. It is unchanged in the other modes and while idle.
- hold_cnt:
  - Reset to 0 on a new grant, including a re-grant after expiry and a grant after idle.
  - Increments (saturating) while the owner is kept.
  - Held at 0 in FP_PREEMPT and while idle.
- Mode change takes effect in the same cycle it is sampled. Switching to FP_PREEMPT lets a higher request preempt the current owner on the next edge. Switching away from FP_PREEMPT locks the present owner from that cycle on.
- Release: when the owner drops req, grant moves to the next winner (or to 0) on the next edge. There are no idle bubble cycles.

## Timing
- Latency: one cycle. req sampled at edge k produces grant after edge k.
- Outputs are purely registered: grant, grant_id and grant_valid change together and carry no combinational path from inputs.
- Asynchronous reset mid-transaction clears every output immediately. The first grant appears one edge after rst_n is released, provided req is set.
- Invariants: grant is never multi-hot. A granted bit always had its req set at the previous edge.

## Structure
- Package arb_pkg holds the arb_mode_e enum (FP_PREEMPT=2'd0, FP_LOCK=2'd1, RR_LOCK=2'd2) and the IDW/hold-width helper functions.
- Sub-module arb_rr_pick: a combinational rotating-priority picker (inputs: candidate vector, start pointer; outputs: one-hot result, index, found).
  - Instantiated twice. With start=0 it provides the fixed-priority pick; with start=rr_ptr it provides the round-robin pick.
- Top level holds the grant, rr_ptr and hold_cnt registers, the keep/expiry logic and the one-hot-to-index encoder.

## Test plan
- FP_PREEMPT, req=4'b1000 then 4'b1010 → grant 4'b1000, then 4'b0010 on the next edge (preemption); grant_id=1.
- FP_LOCK, owner 3 holds, then req=4'b1111 → grant stays 4'b1000 until req[3] drops, then 4'b0001.
- RR_LOCK, req=4'b1111 constant with each owner releasing after 1 cycle → grant sequence 0,1,2,3,0; rr_ptr wraps 3→0.
- MAX_HOLD=4, RR_LOCK, req=4'b0011 held constant → owner 0 for 4 cycles, then owner 1. Single requestor held constant → re-granted, hold_cnt returns to 0.
- rst_n asserted while grant=4'b0100 → grant/grant_id/grant_valid go to 0 immediately. After release with req=4'b0100 → grant returns one edge later, rr_ptr=0.
- Random req/mode for 10k cycles → grant one-hot or zero, grant_valid = |grant, grant_id consistent with grant.
